// File: rtl/dx_pipe_hazard.sv
// rv32i decode+execute core: D decode/regfile read, registered D->E and E->M; M outputs 1 cycle after accept.
// stallD holds fetch on RAW hazards; define FORWARDING_EN for M/W bypass (then only load-use stalls).
module dx_pipe_hazard #(
  parameter int DPW = 32,
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    instrD,
  input  logic           instr_validD,
  output logic           stallD,
  input  logic           flushE,
  input  logic           we,
  input  logic [ADW-1:0] addr_3,
  input  logic [DPW-1:0] wd_3,
  output logic           validM,
  output logic           regwriteM,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic           illegalM,
  output logic [DPW-1:0] aluresultM,
  output logic [DPW-1:0] Rd2M,
  output logic [ADW-1:0] RdM
);

  localparam int NREG = 2**ADW;
  localparam int SHW  = $clog2(DPW);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // ---------------- D stage ----------------
  logic [6:0]     opD, f7D;
  logic [2:0]     f3D;
  logic [ADW-1:0] rs1D, rs2D, rdD;
  logic [DPW-1:0] immiD, immsD;

  assign opD   = instrD[6:0];
  assign f3D   = instrD[14:12];
  assign f7D   = instrD[31:25];
  assign rs1D  = ADW'(instrD[19:15]);
  assign rs2D  = ADW'(instrD[24:20]);
  assign rdD   = ADW'(instrD[11:7]);
  assign immiD = {{(DPW-12){instrD[31]}}, instrD[31:20]};
  assign immsD = {{(DPW-12){instrD[31]}}, instrD[31:25], instrD[11:7]};

  logic           regwriteD, memwriteD, resultsrcD, illegalD;
  logic           use1D, use2D, immselD, altD;
  logic [2:0]     fnD;
  logic [DPW-1:0] immD;

  always_comb begin
    regwriteD  = 1'b0;
    memwriteD  = 1'b0;
    resultsrcD = 1'b0;
    illegalD   = 1'b0;
    use1D      = 1'b0;
    use2D      = 1'b0;
    immselD    = 1'b0;
    altD       = 1'b0;
    fnD        = 3'b000;
    immD       = '0;
    case (opD)
      OP_R: begin
        if (f7D == 7'b0000000 ||
            (f7D == 7'b0100000 && (f3D == 3'b000 || f3D == 3'b101))) begin
          regwriteD = 1'b1;
          use1D     = 1'b1;
          use2D     = 1'b1;
          altD      = f7D[5];
          fnD       = f3D;
        end else begin
          illegalD  = 1'b1;
        end
      end
      OP_I: begin
        if ((f3D == 3'b001 && f7D != 7'b0000000) ||
            (f3D == 3'b101 && f7D != 7'b0000000 && f7D != 7'b0100000)) begin
          illegalD  = 1'b1;
        end else begin
          regwriteD = 1'b1;
          use1D     = 1'b1;
          immselD   = 1'b1;
          altD      = (f3D == 3'b101) && f7D[5];
          fnD       = f3D;
          immD      = immiD;
        end
      end
      OP_LD: begin
        if (f3D == 3'b010) begin
          regwriteD  = 1'b1;
          resultsrcD = 1'b1;
          use1D      = 1'b1;
          immselD    = 1'b1;
          immD       = immiD;
        end else begin
          illegalD   = 1'b1;
        end
      end
      OP_ST: begin
        if (f3D == 3'b010) begin
          memwriteD = 1'b1;
          use1D     = 1'b1;
          use2D     = 1'b1;
          immselD   = 1'b1;
          immD      = immsD;
        end else begin
          illegalD  = 1'b1;
        end
      end
      default: illegalD = 1'b1;
    endcase
  end

  // Register file; x0 is never written so it always reads zero.
  logic [DPW-1:0] rf [NREG];
  logic [DPW-1:0] rd1D, rd2D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we && addr_3 != '0) begin
      rf[addr_3] <= wd_3;
    end
  end

  assign rd1D = (we && addr_3 == rs1D && rs1D != '0) ? wd_3 : rf[rs1D];
  assign rd2D = (we && addr_3 == rs2D && rs2D != '0) ? wd_3 : rf[rs2D];

  // ---------------- hazard detection ----------------
  logic           validE, regwriteE, memwriteE, resultsrcE, illegalE, immselE, altE;
  logic [2:0]     fnE;
  logic [ADW-1:0] RdE;
  logic [DPW-1:0] rd1E, rd2E, immE;
  logic           hit_e, hazard, takeD;

  assign hit_e = validE && regwriteE && RdE != '0 &&
                 ((use1D && rs1D == RdE) || (use2D && rs2D == RdE));

`ifdef FORWARDING_EN
  assign hazard = hit_e && resultsrcE;
`else
  logic hit_m;
  assign hit_m  = validM && regwriteM && RdM != '0 &&
                  ((use1D && rs1D == RdM) || (use2D && rs2D == RdM));
  assign hazard = hit_e || hit_m;
`endif

  // Flush wins: the held D instruction is dropped rather than stalled.
  assign stallD = instr_validD && hazard && !flushE;
  assign takeD  = instr_validD && !hazard && !flushE;

  // ---------------- D->E boundary ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validE     <= 1'b0;
      regwriteE  <= 1'b0;
      memwriteE  <= 1'b0;
      resultsrcE <= 1'b0;
      illegalE   <= 1'b0;
      immselE    <= 1'b0;
      altE       <= 1'b0;
      fnE        <= 3'b000;
      RdE        <= '0;
      rd1E       <= '0;
      rd2E       <= '0;
      immE       <= '0;
    end else if (takeD) begin
      validE     <= 1'b1;
      regwriteE  <= regwriteD;
      memwriteE  <= memwriteD;
      resultsrcE <= resultsrcD;
      illegalE   <= illegalD;
      immselE    <= immselD;
      altE       <= altD;
      fnE        <= fnD;
      RdE        <= rdD;
      rd1E       <= rd1D;
      rd2E       <= rd2D;
      immE       <= immD;
    end else begin
      validE     <= 1'b0;
      regwriteE  <= 1'b0;
      memwriteE  <= 1'b0;
      resultsrcE <= 1'b0;
      illegalE   <= 1'b0;
    end
  end

  // ---------------- E stage ----------------
  logic [DPW-1:0] srcaE, fwdbE, srcbE, aluE;
  logic [SHW-1:0] shamt;

`ifdef FORWARDING_EN
  logic [ADW-1:0] rs1E, rs2E;
  logic           m_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1E <= '0;
      rs2E <= '0;
    end else if (takeD) begin
      rs1E <= use1D ? rs1D : '0;
      rs2E <= use2D ? rs2D : '0;
    end
  end

  // Loads are excluded from M bypass; their data only exists at W.
  assign m_fwd = validM && regwriteM && !resultsrcM;
  assign srcaE = (m_fwd && rs1E != '0 && RdM == rs1E)    ? aluresultM :
                 (we && rs1E != '0 && addr_3 == rs1E)    ? wd_3 : rd1E;
  assign fwdbE = (m_fwd && rs2E != '0 && RdM == rs2E)    ? aluresultM :
                 (we && rs2E != '0 && addr_3 == rs2E)    ? wd_3 : rd2E;
`else
  assign srcaE = rd1E;
  assign fwdbE = rd2E;
`endif

  assign srcbE = immselE ? immE : fwdbE;
  assign shamt = srcbE[SHW-1:0];

  always_comb begin
    aluE = '0;
    case (fnE)
      3'b000: aluE = altE ? (srcaE - srcbE) : (srcaE + srcbE);
      3'b001: aluE = srcaE << shamt;
      3'b010: aluE = {{(DPW-1){1'b0}}, ($signed(srcaE) < $signed(srcbE))};
      3'b011: aluE = {{(DPW-1){1'b0}}, (srcaE < srcbE)};
      3'b100: aluE = srcaE ^ srcbE;
      3'b101: aluE = altE ? $unsigned($signed(srcaE) >>> shamt) : (srcaE >> shamt);
      3'b110: aluE = srcaE | srcbE;
      default: aluE = srcaE & srcbE;
    endcase
  end

  // ---------------- E->M boundary ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validM     <= 1'b0;
      regwriteM  <= 1'b0;
      resultsrcM <= 1'b0;
      memwriteM  <= 1'b0;
      illegalM   <= 1'b0;
      aluresultM <= '0;
      Rd2M       <= '0;
      RdM        <= '0;
    end else begin
      validM     <= validE;
      regwriteM  <= validE && regwriteE;
      resultsrcM <= validE && resultsrcE;
      memwriteM  <= validE && memwriteE;
      illegalM   <= validE && illegalE;
      aluresultM <= aluE;
      Rd2M       <= fwdbE;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_dx_pipe_hazard.sv
// Directed bench for dx_pipe_hazard; the bench plays the fetch and W stages.
module tb_dx_pipe_hazard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrD;
  logic        instr_validD;
  logic        stallD;
  logic        flushE;
  logic        we;
  logic [4:0]  addr_3;
  logic [31:0] wd_3;
  logic        validM, regwriteM, resultsrcM, memwriteM, illegalM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;

  localparam logic [31:0] LOAD_DATA = 32'h10;
  localparam logic [6:0]  OPI  = 7'b0010011;
  localparam logic [6:0]  OPLD = 7'b0000011;
`ifdef FORWARDING_EN
  localparam int RAW_STALL = 0;
  localparam int LU_STALL  = 1;
`else
  localparam int RAW_STALL = 2;
  localparam int LU_STALL  = 2;
`endif

  dx_pipe_hazard #(.DPW(32), .ADW(5)) dut (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .instr_validD(instr_validD),
    .stallD(stallD), .flushE(flushE), .we(we), .addr_3(addr_3), .wd_3(wd_3),
    .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
    .memwriteM(memwriteM), .illegalM(illegalM), .aluresultM(aluresultM),
    .Rd2M(Rd2M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  // One clock; the M result seen this cycle is presented on the W port next cycle.
  task automatic cyc();
    logic        nwe;
    logic [4:0]  na;
    logic [31:0] nd;
    nwe = validM && regwriteM;
    na  = RdM;
    nd  = resultsrcM ? LOAD_DATA : aluresultM;
    @(posedge clk);
    #1;
    we     = nwe;
    addr_3 = na;
    wd_3   = nd;
  endtask

  task automatic idle(input int n);
    instr_validD = 1'b0;
    repeat (n) cyc();
  endtask

  // Present an instruction, hold it while stalled, return after its accept edge.
  task automatic issue(input logic [31:0] ins, output int stalls);
    stalls       = 0;
    instrD       = ins;
    instr_validD = 1'b1;
    #1;
    while (stallD && stalls < 8) begin
      stalls++;
      cyc();
      #1;
    end
    if (stalls >= 8) chk("stall_bound", 32'(stallD), 32'd0);
    cyc();
    instr_validD = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    rst_n = 1'b0; instrD = '0; instr_validD = 1'b0; flushE = 1'b0;
    we = 1'b0; addr_3 = '0; wd_3 = '0;
    #12;
    chk("rst_validM", 32'(validM), 32'd0);
    chk("rst_regwriteM", 32'(regwriteM), 32'd0);
    chk("rst_memwriteM", 32'(memwriteM), 32'd0);
    chk("rst_illegalM", 32'(illegalM), 32'd0);
    chk("rst_aluresultM", aluresultM, 32'd0);
    chk("rst_Rd2M", Rd2M, 32'd0);
    chk("rst_RdM", 32'(RdM), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // back-to-back RAW
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd1, OPI), s);
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), s);
    chk("b2b_stalls", 32'(s), 32'(RAW_STALL));
    cyc();
    chk("b2b_validM", 32'(validM), 32'd1);
    chk("b2b_regwriteM", 32'(regwriteM), 32'd1);
    chk("b2b_alu", aluresultM, 32'd14);
    chk("b2b_rd", 32'(RdM), 32'd2);
    idle(3);

    // load outputs, then load-use
    issue(enc_i(12'd4, 5'd0, 3'b010, 5'd20, OPLD), s);
    cyc();
    chk("lw_resultsrcM", 32'(resultsrcM), 32'd1);
    chk("lw_addr", aluresultM, 32'd4);
    chk("lw_regwriteM", 32'(regwriteM), 32'd1);
    idle(3);
    issue(enc_i(12'd0, 5'd0, 3'b010, 5'd3, OPLD), s);
    issue(enc_i(12'd1, 5'd3, 3'b000, 5'd4, OPI), s);
    chk("lu_stalls", 32'(s), 32'(LU_STALL));
    cyc();
    chk("lu_alu", aluresultM, 32'h11);
    chk("lu_rd", 32'(RdM), 32'd4);
    idle(3);

    // flush on accept edge
    instrD = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OPI);
    instr_validD = 1'b1; flushE = 1'b1;
    #1;
    chk("flush_stallD", 32'(stallD), 32'd0);
    cyc();
    flushE = 1'b0; instr_validD = 1'b0;
    cyc();
    chk("flush_validM", 32'(validM), 32'd0);
    chk("flush_regwriteM", 32'(regwriteM), 32'd0);
    idle(2);
    issue(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd7), s);
    cyc();
    chk("flush_x5", aluresultM, 32'd0);
    idle(3);

    // flush while a dependant would stall
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd21, OPI), s);
    instrD = enc_r(7'h00, 5'd0, 5'd21, 3'b000, 5'd22);
    instr_validD = 1'b1; flushE = 1'b1;
    #1;
    chk("flush_stall_prio", 32'(stallD), 32'd0);
    cyc();
    flushE = 1'b0; instr_validD = 1'b0;
    cyc();
    chk("flush_drop_validM", 32'(validM), 32'd0);
    idle(3);

    // x0 destination
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI), s);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9), s);
    chk("x0_stalls", 32'(s), 32'd0);
    chk("x0_regwriteM", 32'(regwriteM), 32'd1);
    chk("x0_RdM", 32'(RdM), 32'd0);
    chk("x0_alu", aluresultM, 32'd5);
    cyc();
    chk("x0_read", aluresultM, 32'd0);
    idle(3);

    // shifts
    issue(enc_i(12'd1, 5'd0, 3'b000, 5'd10, OPI), s);
    issue(enc_i(12'd31, 5'd10, 3'b001, 5'd10, OPI), s);
    issue(enc_i(12'd31, 5'd0, 3'b000, 5'd11, OPI), s);
    issue(enc_r(7'h20, 5'd11, 5'd10, 3'b101, 5'd12), s);
    cyc();
    chk("sra", aluresultM, 32'hFFFF_FFFF);
    issue(enc_r(7'h00, 5'd11, 5'd10, 3'b101, 5'd13), s);
    cyc();
    chk("srl", aluresultM, 32'd1);
    idle(3);

    // compares and logic on 1 vs 0xFFFFFFFF
    issue(enc_i(12'd1, 5'd0, 3'b000, 5'd14, OPI), s);
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd15, OPI), s);
    issue(enc_r(7'h00, 5'd15, 5'd14, 3'b011, 5'd16), s);
    cyc();
    chk("sltu", aluresultM, 32'd1);
    issue(enc_r(7'h00, 5'd15, 5'd14, 3'b010, 5'd17), s);
    cyc();
    chk("slt", aluresultM, 32'd0);
    issue(enc_r(7'h20, 5'd15, 5'd14, 3'b000, 5'd18), s);
    cyc();
    chk("sub", aluresultM, 32'd2);
    issue(enc_r(7'h00, 5'd15, 5'd14, 3'b100, 5'd19), s);
    cyc();
    chk("xor", aluresultM, 32'hFFFF_FFFE);
    issue(enc_s(12'd8, 5'd15, 5'd14), s);
    cyc();
    chk("sw_memwriteM", 32'(memwriteM), 32'd1);
    chk("sw_regwriteM", 32'(regwriteM), 32'd0);
    chk("sw_addr", aluresultM, 32'd9);
    chk("sw_data", Rd2M, 32'hFFFF_FFFF);
    idle(3);

    // illegal opcode
    issue(32'h0000_007F, s);
    cyc();
    chk("ill_illegalM", 32'(illegalM), 32'd1);
    chk("ill_regwriteM", 32'(regwriteM), 32'd0);
    chk("ill_memwriteM", 32'(memwriteM), 32'd0);
    chk("ill_validM", 32'(validM), 32'd1);
    cyc();
    chk("ill_clear", 32'(illegalM), 32'd0);
    idle(2);

    // reset mid-stream
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), s);
    cyc();
    chk("mid_validM", 32'(validM), 32'd1);
    #1;
    rst_n = 1'b0;
    we = 1'b0;
    #1;
    chk("mid_rst_validM", 32'(validM), 32'd0);
    chk("mid_rst_regwriteM", 32'(regwriteM), 32'd0);
    chk("mid_rst_alu", aluresultM, 32'd0);
    chk("mid_rst_RdM", 32'(RdM), 32'd0);
    #1;
    rst_n = 1'b1;
    idle(2);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd23), s);
    cyc();
    chk("mid_x1", aluresultM, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
